// File: rtl/bip_debug_pkg.sv
// Shared types and constants for the BIP debug report transmitter.
// Packet framing constants and the two FSM state encodings.
package bip_debug_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int PKT_BYTES = 9;

  typedef enum logic [1:0] {
    P_IDLE,
    P_SEND,
    P_FIN
  } pkt_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

endpackage

// File: rtl/bip_debug_tx_uart.sv
// 8N1 byte serializer with its own baud counter.
// ready also rises in the final stop cycle so frames chain back-to-back.
module uart_tx_byte
  import bip_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  byte_state_t state, nstate;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx, nbit;
  logic [7:0]    dreg;
  logic          wrap, accept, tx_d;

  assign wrap = cnt == LAST;

  always_ff @(posedge CLK) begin
    if (!RESET) state <= B_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      B_IDLE:  if (valid) nstate = B_START;
      B_START: if (wrap) nstate = B_DATA;
      B_DATA:  if (wrap && bit_idx == 3'd7) nstate = B_STOP;
      B_STOP:  if (wrap) nstate = valid ? B_START : B_IDLE;
      default: nstate = B_IDLE;
    endcase
  end

  always_comb begin
    ready  = (state == B_IDLE) || (state == B_STOP && wrap);
    accept = ready && valid;
    nbit   = bit_idx;
    if (state == B_START)        nbit = 3'd0;
    if (state == B_DATA && wrap) nbit = bit_idx + 3'd1;
    unique case (nstate)
      B_START: tx_d = 1'b0;
      B_DATA:  tx_d = dreg[nbit];
      default: tx_d = 1'b1;
    endcase
  end

  // tx comes straight from a flop so the line never glitches
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt     <= '0;
      bit_idx <= '0;
      dreg    <= '0;
      tx      <= 1'b1;
    end else begin
      tx      <= tx_d;
      bit_idx <= nbit;
      if (accept) begin
        cnt  <= '0;
        dreg <= data;
      end else if (state != B_IDLE) begin
        cnt <= wrap ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/bip_debug_tx.sv
// Latches final BIP state on HALT and reports it as a 9-byte UART packet.
// Owns edge detect, capture, byte mux, packet FSM, BUSY and DONE.
module bip_debug_tx
  import bip_debug_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int PC_W         = 11,
  parameter int DATA_W       = 16,
  parameter int CNT_W        = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              HALT,
  input  logic [PC_W-1:0]   PC,
  input  logic [DATA_W-1:0] ACC,
  input  logic [CNT_W-1:0]  CYCLES,
  output logic              TX,
  output logic              BUSY,
  output logic              DONE
);

  pkt_state_t state, nstate;
  logic              halt_q, busy_q, start, last;
  logic              valid, ready;
  logic [3:0]        byte_idx;
  logic [PC_W-1:0]   pc_l;
  logic [DATA_W-1:0] acc_l;
  logic [CNT_W-1:0]  cyc_l;
  logic [15:0]       pc16, acc16;
  logic [31:0]       cyc32;
  logic [7:0]        byte_d;

  // SEND is excluded too: BUSY lags the state by one cycle
  assign start = HALT && !halt_q && !busy_q && (state != P_SEND);
  assign last  = byte_idx == 4'(PKT_BYTES);
  assign BUSY  = busy_q;

  always_ff @(posedge CLK) begin
    if (!RESET) state <= P_IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      P_IDLE:  if (start) nstate = P_SEND;
      P_SEND:  if (last && ready) nstate = P_FIN;
      P_FIN:   nstate = start ? P_SEND : P_IDLE;
      default: nstate = P_IDLE;
    endcase
  end

  always_comb begin
    valid = (state == P_SEND) && !last;
    DONE  = state == P_FIN;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      halt_q   <= 1'b0;
      busy_q   <= 1'b0;
      byte_idx <= '0;
      pc_l     <= '0;
      acc_l    <= '0;
      cyc_l    <= '0;
    end else begin
      halt_q <= HALT;
      if (start) begin
        pc_l     <= PC;
        acc_l    <= ACC;
        cyc_l    <= CYCLES;
        byte_idx <= '0;
      end else if (valid && ready) begin
        byte_idx <= byte_idx + 4'd1;
      end
      if (valid && ready)
        busy_q <= 1'b1;
      else if (state == P_SEND && last && ready)
        busy_q <= 1'b0;
    end
  end

  assign pc16  = 16'(pc_l);
  assign acc16 = 16'(acc_l);
  assign cyc32 = 32'(cyc_l);

  always_comb begin
    case (byte_idx)
      4'd1:    byte_d = pc16[7:0];
      4'd2:    byte_d = pc16[15:8];
      4'd3:    byte_d = acc16[7:0];
      4'd4:    byte_d = acc16[15:8];
      4'd5:    byte_d = cyc32[7:0];
      4'd6:    byte_d = cyc32[15:8];
      4'd7:    byte_d = cyc32[23:16];
      4'd8:    byte_d = cyc32[31:24];
      default: byte_d = SYNC_BYTE;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .CLK  (CLK),
    .RESET(RESET),
    .data (byte_d),
    .valid(valid),
    .ready(ready),
    .tx   (TX)
  );

endmodule

// File: tb/tb_bip_debug_tx.sv
// Self-checking bench for bip_debug_tx: table vectors, random packets,
// and hand-written lockout, reset and held-HALT sequences.
module tb_bip_debug_tx;

  localparam int C   = 4;
  localparam int PKT = 90 * C;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        HALT;
  logic [10:0] PC;
  logic [15:0] ACC;
  logic [31:0] CYCLES;
  logic        TX, BUSY, DONE;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [10:0] pc;
    logic [15:0] acc;
    logic [31:0] cyc;
    logic [71:0] exp;
  } vec_t;

  vec_t tbl [3];

  always #5 CLK = ~CLK;

  bip_debug_tx #(
    .CLKS_PER_BIT(C),
    .PC_W        (11),
    .DATA_W      (16),
    .CNT_W       (32)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .HALT  (HALT),
    .PC    (PC),
    .ACC   (ACC),
    .CYCLES(CYCLES),
    .TX    (TX),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  task automatic chk(input string name, input logic [71:0] got,
                     input logic [71:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // packet bytes from the field layout, byte 0 in the low bits
  function automatic logic [71:0] model_pkt(input int unsigned pc,
      input int unsigned acc, input int unsigned cyc);
    int unsigned b [9];
    logic [71:0] p;
    b[0] = 165;
    b[1] = pc % 256;
    b[2] = (pc / 256) % 256;
    b[3] = acc % 256;
    b[4] = (acc / 256) % 256;
    b[5] = cyc % 256;
    b[6] = (cyc / 256) % 256;
    b[7] = (cyc / 65536) % 256;
    b[8] = (cyc / 16777216) % 256;
    p = '0;
    for (int i = 0; i < 9; i++) p[8*i +: 8] = 8'(b[i]);
    return p;
  endfunction

  // expected line level t cycles after the first start-bit fall
  function automatic logic exp_bit(input logic [71:0] p, input int t);
    int f, pos;
    f   = t / (10 * C);
    pos = (t % (10 * C)) / C;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return p[8*f + pos - 1];
  endfunction

  task automatic quiet(input int n, input string tag);
    int e = 0;
    repeat (n) begin
      if (TX !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0) e++;
      @(negedge CLK);
    end
    chk(tag, 72'(e), 72'd0);
  endtask

  task automatic run_packet(input logic [10:0] pc, input logic [15:0] acc,
      input logic [31:0] cyc, input logic [71:0] exp, input int lock_at,
      input bit hold, input string tag);
    logic [PKT-1:0] rec;
    logic [7:0]     gb;
    int werr = 0;
    int berr = 0;
    PC = pc;
    ACC = acc;
    CYCLES = cyc;
    HALT = 1'b1;
    @(negedge CLK);
    chk({tag, "_pre_fall"}, 72'(TX), 72'd1);
    @(negedge CLK);
    chk({tag, "_fall"}, 72'(TX), 72'd0);
    for (int t = 0; t < PKT; t++) begin
      rec[t] = TX;
      if (TX !== exp_bit(exp, t)) werr++;
      if (BUSY !== 1'b1 || DONE !== 1'b0) berr++;
      if (t == 2 && !hold) HALT = 1'b0;
      if (t == 5) begin
        PC = 11'($urandom);
        ACC = 16'($urandom);
        CYCLES = $urandom;
      end
      if (lock_at >= 0 && t == lock_at) begin
        PC = 11'h7FF;
        HALT = 1'b1;
      end
      if (lock_at >= 0 && t == lock_at + 2) HALT = 1'b0;
      @(negedge CLK);
    end
    chk({tag, "_wave"}, 72'(werr), 72'd0);
    chk({tag, "_busy"}, 72'(berr), 72'd0);
    chk({tag, "_done"}, 72'({DONE, BUSY, TX}), 72'b101);
    for (int j = 0; j < 9; j++) begin
      for (int b = 0; b < 8; b++)
        gb[b] = rec[j*10*C + (b+1)*C + C/2];
      chk($sformatf("%s_byte%0d", tag, j), 72'(gb), 72'(exp[8*j +: 8]));
    end
    @(negedge CLK);
    chk({tag, "_done_end"}, 72'(DONE), 72'd0);
  endtask

  initial begin
    logic [10:0] pc;
    logic [15:0] acc;
    logic [31:0] cyc;

    tbl[0] = '{11'h123, 16'hBEEF, 32'h0001_0203,
               72'h00_01_02_03_BE_EF_01_23_A5};
    tbl[1] = '{11'h7FF, 16'h0000, 32'hFFFF_FFFF,
               72'hFF_FF_FF_FF_00_00_07_FF_A5};
    tbl[2] = '{11'h000, 16'h8001, 32'h8000_0001,
               72'h80_00_00_01_80_01_00_00_A5};

    RESET = 1'b0;
    HALT = 1'b1;
    PC = '0;
    ACC = '0;
    CYCLES = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("reset_%0d", i), 72'({TX, BUSY, DONE}), 72'b100);
    end
    RESET = 1'b1;
    HALT = 1'b0;
    quiet(100, "post_reset_idle");

    for (int i = 0; i < 3; i++)
      run_packet(tbl[i].pc, tbl[i].acc, tbl[i].cyc, tbl[i].exp, -1, 1'b0,
                 $sformatf("tbl%0d", i));

    for (int i = 0; i < 5; i++) begin
      pc = 11'($urandom);
      acc = 16'($urandom);
      cyc = $urandom;
      run_packet(pc, acc, cyc, model_pkt(pc, acc, cyc), -1, 1'b0,
                 $sformatf("rnd%0d", i));
    end

    run_packet(tbl[0].pc, tbl[0].acc, tbl[0].cyc, tbl[0].exp, 100, 1'b0,
               "lock");
    quiet(200, "lock_no_second");
    acc = 16'($urandom);
    cyc = $urandom;
    run_packet(11'h7FF, acc, cyc, model_pkt(32'h7FF, acc, cyc), -1, 1'b0,
               "fresh");

    HALT = 1'b1;
    @(negedge CLK);
    HALT = 1'b0;
    @(negedge CLK);
    repeat (32 * C) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    chk("midreset", 72'({TX, BUSY, DONE}), 72'b100);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    quiet(60, "midreset_quiet");
    run_packet(tbl[0].pc, tbl[0].acc, tbl[0].cyc, tbl[0].exp, -1, 1'b0,
               "after_reset");

    run_packet(tbl[1].pc, tbl[1].acc, tbl[1].cyc, tbl[1].exp, -1, 1'b1,
               "hold");
    quiet(200, "hold_no_retrigger");
    HALT = 1'b0;
    @(negedge CLK);
    run_packet(tbl[2].pc, tbl[2].acc, tbl[2].cyc, tbl[2].exp, -1, 1'b0,
               "rehold");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
